// File: rtl/median_pkg.sv
// Shared types and constants for the windowed median engine.
package median_pkg;

   typedef enum logic [1:0] {
      MED_LOAD = 2'd0,
      MED_SORT = 2'd1,
      MED_OUT  = 2'd2
   } med_state_t;

   localparam int MED_N_DEFAULT = 9;
   localparam int MED_W_DEFAULT = 8;

   // Counter width able to hold values 0..n inclusive.
   function automatic int med_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bitonic_sort_2.sv
// Two-input unsigned compare-exchange cell; equal inputs keep their order.
module bitonic_sort_2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);

   logic keep;

   assign keep = (i_a <= i_b);
   assign o_lo = keep ? i_a : i_b;
   assign o_hi = keep ? i_b : i_a;

endmodule

// File: rtl/median_oets_stage.sv
// One odd-even transposition phase over the whole window, purely combinational.
module median_oets_stage
   import median_pkg::*;
#(
   parameter int WIDTH = MED_W_DEFAULT,
   parameter int N     = MED_N_DEFAULT
) (
   input  logic [N-1:0][WIDTH-1:0] array_in,
   input  logic                    phase_odd,
   output logic [N-1:0][WIDTH-1:0] array_out
);

   localparam int PAIRS = (N - 1) / 2;

   logic [PAIRS-1:0][WIDTH-1:0] cell_a;
   logic [PAIRS-1:0][WIDTH-1:0] cell_b;
   logic [PAIRS-1:0][WIDTH-1:0] cell_lo;
   logic [PAIRS-1:0][WIDTH-1:0] cell_hi;

   // Each cell serves pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases.
   for (genvar k = 0; k < PAIRS; k++) begin : g_cell
      assign cell_a[k] = phase_odd ? array_in[2*k+1] : array_in[2*k];
      assign cell_b[k] = phase_odd ? array_in[2*k+2] : array_in[2*k+1];

      bitonic_sort_2 #(.WIDTH(WIDTH)) u_cell (
         .i_a  (cell_a[k]),
         .i_b  (cell_b[k]),
         .o_lo (cell_lo[k]),
         .o_hi (cell_hi[k])
      );
   end

   for (genvar i = 0; i < N; i++) begin : g_out
      logic [WIDTH-1:0] even_v;
      logic [WIDTH-1:0] odd_v;

      if (i == N - 1) begin : g_even_pass
         assign even_v = array_in[i];
      end else if ((i % 2) == 0) begin : g_even_lo
         assign even_v = cell_lo[i/2];
      end else begin : g_even_hi
         assign even_v = cell_hi[i/2];
      end

      if (i == 0) begin : g_odd_pass
         assign odd_v = array_in[i];
      end else if ((i % 2) == 1) begin : g_odd_lo
         assign odd_v = cell_lo[(i-1)/2];
      end else begin : g_odd_hi
         assign odd_v = cell_hi[(i-2)/2];
      end

      assign array_out[i] = phase_odd ? odd_v : even_v;
   end

endmodule

// File: rtl/median_window_sorter.sv
// Serial-in window sorter: load N samples, run N transposition phases, present median/min/max.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module median_window_sorter
   import median_pkg::*;
#(
   parameter int WIDTH = MED_W_DEFAULT,
   parameter int N     = MED_N_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_sample,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_median,
   output logic [WIDTH-1:0] o_min,
   output logic [WIDTH-1:0] o_max,
   output logic             o_busy
);

   localparam int CNT_W = med_cnt_w(N);
   localparam int MID   = (N - 1) / 2;

   if ((N % 2) == 0 || N < 3 || N > 15) begin : g_bad_n
      $error("median_window_sorter: N must be odd and within 3..15");
   end

   med_state_t                state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]          phase_q, phase_d;
   logic [N-1:0][WIDTH-1:0]   arr_q, arr_d;
   logic [N-1:0][WIDTH-1:0]   sorted;
   logic                      accept;

   median_oets_stage #(.WIDTH(WIDTH), .N(N)) u_stage (
      .array_in  (arr_q),
      .phase_odd (phase_q[0]),
      .array_out (sorted)
   );

   assign accept = (state_q == MED_LOAD) && i_valid;

   // Per-slot next value: sort result while sorting, otherwise the addressed load slot.
   for (genvar i = 0; i < N; i++) begin : g_arr
      assign arr_d[i] = (state_q == MED_SORT)                  ? sorted[i] :
                        (accept && (cnt_q == CNT_W'(i)))       ? i_sample  :
                                                                 arr_q[i];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      case (state_q)
         MED_LOAD: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(N - 1)) begin
                  state_d = MED_SORT;
                  phase_d = '0;
               end
            end
         end
         MED_SORT: begin
            phase_d = phase_q + 1'b1;
            if (phase_q == CNT_W'(N - 1)) begin
               state_d = MED_OUT;
            end
         end
         MED_OUT: begin
            if (i_ready) begin
               state_d = MED_LOAD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = MED_LOAD;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= MED_LOAD;
         cnt_q   <= '0;
         phase_q <= '0;
         arr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         arr_q   <= arr_d;
      end
   end

   assign o_ready  = (state_q == MED_LOAD) && !i_rst;
   assign o_valid  = (state_q == MED_OUT);
   assign o_busy   = (state_q != MED_LOAD);
   assign o_median = arr_q[MID];
   assign o_min    = arr_q[0];
   assign o_max    = arr_q[N-1];

endmodule

// File: tb/tb_median_window_sorter.sv
// Directed bench for median_window_sorter with a result scoreboard.
module tb_median_window_sorter;

   localparam int W   = 8;
   localparam int N   = 9;
   localparam int TMO = 200;

   typedef logic [W-1:0] win_t [N];

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_sample;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_median;
   logic [W-1:0] o_min;
   logic [W-1:0] o_max;
   logic         o_busy;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int acc_cyc    = 0;

   logic [3*W-1:0] exp_q[$];
   int             res_cyc[$];

   median_window_sorter #(.WIDTH(W), .N(N)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_sample (i_sample),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_median (o_median),
      .o_min    (o_min),
      .o_max    (o_max),
      .o_busy   (o_busy)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [3*W-1:0] model(input win_t s);
      win_t t;
      logic [W-1:0] tmp;
      t = s;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N - 1 - i; j++) begin
            if (t[j] > t[j+1]) begin
               tmp    = t[j];
               t[j]   = t[j+1];
               t[j+1] = tmp;
            end
         end
      end
      return {t[(N-1)/2], t[0], t[N-1]};
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge i_clk) begin
      logic [3*W-1:0] e;
      if (i_rst === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
         res_cyc.push_back(cyc);
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL unexpected_result observed=%h expected=none", {o_median, o_min, o_max});
         end else begin
            e = exp_q.pop_front();
            assert ({o_median, o_min, o_max} === e) else begin
               mismatched++;
               $error("FAIL result observed=%h expected=%h", {o_median, o_min, o_max}, e);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic timeout_fail(input string tag);
      compared++;
      mismatched++;
      $error("FAIL %s observed=timeout expected=event within %0d cycles", tag, TMO);
   endtask

   task automatic send_window(input win_t s, input bit push, input bit hold);
      int guard;
      if (push) exp_q.push_back(model(s));
      for (int i = 0; i < N; i++) begin
         i_sample = s[i];
         i_valid  = 1'b1;
         guard    = 0;
         while (o_ready !== 1'b1 && guard < TMO) begin
            tick();
            guard++;
         end
         if (guard >= TMO) begin
            timeout_fail("send_ready");
            i_valid = 1'b0;
            return;
         end
         acc_cyc = cyc;
         tick();
      end
      if (!hold) i_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      int guard;
      guard = 0;
      lat   = -1;
      while (o_valid !== 1'b1 && guard < TMO) begin
         tick();
         guard++;
      end
      if (guard >= TMO) timeout_fail("wait_valid");
      else lat = cyc - acc_cyc;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      win_t w;
      win_t ws [3];
      int lat;
      int guard;
      logic [3*W-1:0] held;

      i_rst    = 1'b1;
      i_valid  = 1'b0;
      i_sample = '0;
      i_ready  = 1'b1;
      repeat (3) tick();
      check("rst_valid",  o_valid,  0);
      check("rst_busy",   o_busy,   0);
      check("rst_median", o_median, 0);
      check("rst_min",    o_min,    0);
      check("rst_max",    o_max,    0);
      i_rst = 1'b0;
      tick();
      check("rst_ready", o_ready, 1);

      // descending window, with latency and busy checks
      w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      send_window(w, 1'b1, 1'b0);
      check("sort_busy",  o_busy,  1);
      check("sort_ready", o_ready, 0);
      wait_valid(lat);
      check("latency_desc", lat, N + 1);
      tick();
      check("idle_busy",  o_busy,  0);
      check("idle_ready", o_ready, 1);

      // all-equal window
      w = '{default: 8'd5};
      send_window(w, 1'b1, 1'b0);
      wait_valid(lat);
      check("latency_equal", lat, N + 1);
      tick();

      // extremes
      w = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128};
      send_window(w, 1'b1, 1'b0);
      wait_valid(lat);
      tick();

      // random window
      for (int i = 0; i < N; i++) w[i] = W'($urandom_range(0, 255));
      send_window(w, 1'b1, 1'b0);
      wait_valid(lat);
      tick();

      // backpressure in OUT with an upstream sample on offer
      i_ready = 1'b0;
      w = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5};
      send_window(w, 1'b1, 1'b0);
      wait_valid(lat);
      held     = model(w);
      i_valid  = 1'b1;
      i_sample = 8'hAA;
      for (int k = 0; k < 5; k++) begin
         check("bp_data",  {o_median, o_min, o_max}, held);
         check("bp_valid", o_valid, 1);
         check("bp_ready", o_ready, 0);
         tick();
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      check("bp_released", o_valid, 0);

      // reset during sort phase 4 discards the window
      w = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd50, 8'd90, 8'd70, 8'd60, 8'd80};
      send_window(w, 1'b0, 1'b0);
      repeat (4) tick();
      i_rst = 1'b1;
      #2;
      i_rst = 1'b0;
      #1;
      check("midrst_busy", o_busy, 0);
      for (int k = 0; k < 15; k++) begin
         check("midrst_no_valid", o_valid, 0);
         tick();
      end
      w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
      send_window(w, 1'b1, 1'b0);
      wait_valid(lat);
      check("latency_after_rst", lat, N + 1);
      tick();

      // back-to-back streaming
      res_cyc.delete();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < N; i++) ws[k][i] = W'($urandom_range(0, 255));
      send_window(ws[0], 1'b1, 1'b1);
      send_window(ws[1], 1'b1, 1'b1);
      send_window(ws[2], 1'b1, 1'b0);
      guard = 0;
      while (res_cyc.size() < 3 && guard < TMO) begin
         tick();
         guard++;
      end
      if (res_cyc.size() < 3) begin
         timeout_fail("stream_results");
      end else begin
         check("stream_gap0", res_cyc[1] - res_cyc[0], 2 * N + 1);
         check("stream_gap1", res_cyc[2] - res_cyc[1], 2 * N + 1);
      end
      repeat (2) tick();
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
